// File: rtl/ibex_pkg.sv
// Shared types for the iterative multiply/divide unit.
package ibex_pkg;

  // M-extension operation selector.
  typedef enum logic [1:0] {
    MD_OP_MULL,
    MD_OP_MULH,
    MD_OP_DIV,
    MD_OP_REM
  } md_op_e;

  // Sequencer states of the iterative multiply/divide unit.
  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_FIX,
    MD_DONE
  } multdiv_iter_state_e;

endpackage

// File: rtl/ibex_multdiv_iter_step.sv
// One CALC iteration of the multiply/divide datapath, purely combinational.
// The accumulator holds {hi, lo}:
//   multiply: hi = partial product, lo = remaining multiplier bits (LSB first)
//   divide:   hi = partial remainder, lo = dividend bits shifting out / quotient
//             bits shifting in
module ibex_multdiv_iter_step #(
  parameter int unsigned Width           = 32,
  parameter int unsigned MulBitsPerCycle = 1
) (
  input  logic                 is_mul_i,
  input  logic [Width-1:0]     operand_i,  // multiplicand (MUL) or divisor (DIV/REM)
  input  logic [2*Width-1:0]   acc_i,
  output logic [2*Width-1:0]   acc_o
);

  logic [Width-1:0]   hi;
  logic [Width-1:0]   lo;
  logic [2*Width-1:0] mul_acc;
  logic [2*Width-1:0] div_acc;

  assign hi = acc_i[2*Width-1:Width];
  assign lo = acc_i[Width-1:0];

  if (MulBitsPerCycle == 2) begin : g_mul2
    logic [Width+1:0] pp;
    logic [Width+1:0] sum;
    // Add the partial products of two multiplier bits, then shift right by two.
    always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      pp = '0;
      if (lo[0]) pp = pp + {2'b00, operand_i};
      if (lo[1]) pp = pp + {1'b0, operand_i, 1'b0};
      sum     = {2'b00, hi} + pp;
      mul_acc = {sum, lo[Width-1:2]};
    end
  end else begin : g_mul1
    logic [Width:0] sum;
    // Add the multiplicand if the current multiplier bit is set, then shift right by one.
    always_comb begin
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand_i} : '0);
      mul_acc = {sum, lo[Width-1:1]};
    end
  end

  logic [Width:0] rem_sh;
  logic [Width:0] trial;

  // Restoring division: shift in the next dividend bit and try to subtract the divisor.
  always_comb begin
    rem_sh = {hi, lo[Width-1]};
    trial  = rem_sh - {1'b0, operand_i};
    if (trial[Width]) begin
      div_acc = {rem_sh[Width-1:0], lo[Width-2:0], 1'b0};
    end else begin
      div_acc = {trial[Width-1:0], lo[Width-2:0], 1'b1};
    end
  end

  assign acc_o = is_mul_i ? mul_acc : div_acc;

endmodule

// File: rtl/ibex_multdiv_iter.sv
// Iterative multiply/divide unit with its own operand datapath, a valid/ready
// result handshake, back-to-back issue, kill, and divide-by-zero early-out.
module ibex_multdiv_iter
  import ibex_pkg::*;
#(
  parameter int unsigned Width           = 32,
  parameter int unsigned MulBitsPerCycle = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             ready_o,
  input  md_op_e           operator_i,
  input  logic [1:0]       signed_mode_i,
  input  logic [Width-1:0] op_a_i,
  input  logic [Width-1:0] op_b_i,
  input  logic             data_ind_timing_i,
  input  logic             kill_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] result_o,
  output logic             busy_o
);

  localparam int unsigned CntW = $clog2(Width);
  localparam logic [CntW-1:0] MulLastCnt = CntW'(Width / MulBitsPerCycle - 1);
  localparam logic [CntW-1:0] DivLastCnt = CntW'(Width - 1);

  multdiv_iter_state_e state_q;
  md_op_e              op_q;
  logic [Width-1:0]    operand_q;
  logic [2*Width-1:0]  acc_q;
  logic                neg_q;
  logic [CntW-1:0]     cnt_q;
  logic [Width-1:0]    result_q;
  logic                valid_q;

  logic               accept;
  logic               in_is_mul;
  logic               a_signed;
  logic               b_signed;
  logic               a_neg;
  logic               b_neg;
  logic               b_zero;
  logic               early_out;
  logic [Width-1:0]   mag_a;
  logic [Width-1:0]   mag_b;
  logic               load_neg;
  logic [2*Width-1:0] load_acc;
  logic [Width-1:0]   load_operand;
  logic [CntW-1:0]    load_cnt;

  assign ready_o  = (state_q == MD_IDLE) | ((state_q == MD_DONE) & ready_i);
  assign accept   = start_i & ready_o & ~kill_i;
  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign busy_o   = (state_q != MD_IDLE);

  // Decode an incoming request into operand magnitudes, result sign and iteration count.
  always_comb begin
    in_is_mul = (operator_i == MD_OP_MULL) | (operator_i == MD_OP_MULH);
    // Divide is signed only for signed x signed; multiply takes each sign bit separately.
    a_signed  = in_is_mul ? signed_mode_i[0] : (signed_mode_i == 2'b11);
    b_signed  = in_is_mul ? signed_mode_i[1] : (signed_mode_i == 2'b11);
    a_neg     = a_signed & op_a_i[Width-1];
    b_neg     = b_signed & op_b_i[Width-1];
    mag_a     = a_neg ? -op_a_i : op_a_i;
    mag_b     = b_neg ? -op_b_i : op_b_i;
    b_zero    = (op_b_i == '0);
    early_out = ~in_is_mul & b_zero & ~data_ind_timing_i;

    unique case (operator_i)
      MD_OP_DIV: load_neg = (a_neg ^ b_neg) & ~b_zero;  // x/0 stays all ones
      MD_OP_REM: load_neg = a_neg;
      default:   load_neg = a_neg ^ b_neg;
    endcase

    if (in_is_mul) begin
      load_acc     = {{Width{1'b0}}, mag_b};
      load_operand = mag_a;
      load_cnt     = MulLastCnt;
    end else begin
      // With a zero divisor the full iteration converges to {|a|, all ones};
      // the early-out loads that result directly so both timings agree.
      load_acc     = early_out ? {mag_a, {Width{1'b1}}} : {{Width{1'b0}}, mag_a};
      load_operand = mag_b;
      load_cnt     = DivLastCnt;
    end
  end

  logic               is_mul_q;
  logic [2*Width-1:0] acc_step;
  logic [2*Width-1:0] prod;
  logic [Width-1:0]   fix_res;

  assign is_mul_q = (op_q == MD_OP_MULL) | (op_q == MD_OP_MULH);

  ibex_multdiv_iter_step #(
    .Width          (Width),
    .MulBitsPerCycle(MulBitsPerCycle)
  ) u_step (
    .is_mul_i (is_mul_q),
    .operand_i(operand_q),
    .acc_i    (acc_q),
    .acc_o    (acc_step)
  );

  // Sign correction and half selection applied in the FIX state.
  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    unique case (op_q)
      MD_OP_MULL: fix_res = prod[Width-1:0];
      MD_OP_MULH: fix_res = prod[2*Width-1:Width];
      MD_OP_DIV:  fix_res = neg_q ? -acc_q[Width-1:0] : acc_q[Width-1:0];
      default:    fix_res = neg_q ? -acc_q[2*Width-1:Width] : acc_q[2*Width-1:Width];
    endcase
  end

  // Sequencer and datapath registers; kill and reset both abandon the operation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state_q   <= MD_IDLE;
      op_q      <= MD_OP_MULL;
      operand_q <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
    end else if (kill_i) begin
      state_q <= MD_IDLE;
      valid_q <= 1'b0;
    end else if (accept) begin
      // Accept is only possible from IDLE or from DONE while the result is consumed.
      op_q      <= operator_i;
      operand_q <= load_operand;
      acc_q     <= load_acc;
      neg_q     <= load_neg;
      cnt_q     <= load_cnt;
      valid_q   <= 1'b0;
      state_q   <= early_out ? MD_FIX : MD_CALC;
    end else begin
      unique case (state_q)
        MD_CALC: begin
          acc_q <= acc_step;
          if (cnt_q == '0) begin
            state_q <= MD_FIX;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        MD_FIX: begin
          result_q <= fix_res;
          valid_q  <= 1'b1;
          state_q  <= MD_DONE;
        end
        MD_DONE: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            state_q <= MD_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Scoreboard bench for the iterative multiply/divide unit. Three instances share
// the request inputs: 32-bit radix-2, 32-bit radix-4 and 8-bit radix-2. sel picks
// the instance whose outputs are observed; kill pulses bring all back to IDLE.
module tb_ibex_multdiv_iter;
  import ibex_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  md_op_e      operator;
  logic [1:0]  signed_mode;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        dit;
  logic        kill;
  logic        rdy;

  logic        ready0, valid0, busy0;
  logic [31:0] result0;
  logic        ready1, valid1, busy1;
  logic [31:0] result1;
  logic        ready2, valid2, busy2;
  logic [7:0]  result2;

  int          sel = 0;
  logic        ready_s, valid_s, busy_s;
  logic [31:0] result_s;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          t0;
    string       name;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ibex_multdiv_iter #(.Width(32), .MulBitsPerCycle(1)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ready_o(ready0), .operator_i(operator),
    .signed_mode_i(signed_mode), .op_a_i(op_a), .op_b_i(op_b), .data_ind_timing_i(dit),
    .kill_i(kill), .valid_o(valid0), .ready_i(rdy), .result_o(result0), .busy_o(busy0)
  );

  ibex_multdiv_iter #(.Width(32), .MulBitsPerCycle(2)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ready_o(ready1), .operator_i(operator),
    .signed_mode_i(signed_mode), .op_a_i(op_a), .op_b_i(op_b), .data_ind_timing_i(dit),
    .kill_i(kill), .valid_o(valid1), .ready_i(rdy), .result_o(result1), .busy_o(busy1)
  );

  ibex_multdiv_iter #(.Width(8), .MulBitsPerCycle(1)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ready_o(ready2), .operator_i(operator),
    .signed_mode_i(signed_mode), .op_a_i(op_a[7:0]), .op_b_i(op_b[7:0]),
    .data_ind_timing_i(dit), .kill_i(kill), .valid_o(valid2), .ready_i(rdy),
    .result_o(result2), .busy_o(busy2)
  );

  always_comb begin
    case (sel)
      1: begin
        ready_s = ready1; valid_s = valid1; busy_s = busy1; result_s = result1;
      end
      2: begin
        ready_s = ready2; valid_s = valid2; busy_s = busy2; result_s = {24'h0, result2};
      end
      default: begin
        ready_s = ready0; valid_s = valid0; busy_s = busy0; result_s = result0;
      end
    endcase
  end

  // Drive one request at a negedge; the following posedge is cycle 0 of the operation.
  task automatic issue(input string name, input md_op_e op, input logic [1:0] mode,
                       input logic [31:0] a, input logic [31:0] b, input logic d,
                       input logic [31:0] res, input int lat);
    exp_t e;
    operator = op; signed_mode = mode; op_a = a; op_b = b; dit = d; start = 1'b1;
    #1;
    checks++;
    if (ready_s !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: ready_o=%b expected 1", name, ready_s);
    end
    e.res = res; e.lat = lat; e.t0 = cyc; e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Wait for valid_o, compare against the oldest expectation, optionally hold off ready_i.
  task automatic wait_result(input int budget, input int hold);
    exp_t e;
    bit   seen = 1'b0;
    e = sb.pop_front();
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (valid_s === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: valid_o not seen within %0d cycles", e.name, budget);
      return;
    end
    if (result_s !== e.res) begin
      errors++;
      $display("FAIL %s result: got %h expected %h", e.name, result_s, e.res);
    end
    checks++;
    if ((cyc - e.t0) != e.lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", e.name, cyc - e.t0, e.lat);
    end
    for (int i = 0; i < hold; i++) begin
      op_a = $urandom; op_b = $urandom; operator = MD_OP_MULH; start = 1'b1;
      @(negedge clk);
      checks++;
      if (valid_s !== 1'b1 || result_s !== e.res) begin
        errors++;
        $display("FAIL %s hold%0d: valid=%b result=%h expected valid=1 result=%h",
                 e.name, i, valid_s, result_s, e.res);
      end
    end
    start = 1'b0;
  endtask

  // Kill pulse to bring every instance back to IDLE; returns at a negedge.
  task automatic resync();
    @(negedge clk);
    start = 1'b0; kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; kill = 1'b0; rdy = 1'b1; dit = 1'b0;
    operator = MD_OP_MULL; signed_mode = 2'b00; op_a = '0; op_b = '0;
    @(negedge clk);
    checks++;
    if (valid0 !== 1'b0 || busy0 !== 1'b0 || ready0 !== 1'b1 || result0 !== 32'h0) begin
      errors++;
      $display("FAIL reset: valid=%b busy=%b ready=%b result=%h expected 0 0 1 0",
               valid0, busy0, ready0, result0);
    end
    checks++;
    if (result2 !== 8'h0 || ready2 !== 1'b1) begin
      errors++;
      $display("FAIL reset_w8: result=%h ready=%b expected 00 1", result2, ready2);
    end
    rst = 1'b0;
  endtask

  task automatic test_mul();
    sel = 0;
    resync(); issue("mull_11", MD_OP_MULL, 2'b11, 32'd7, 32'hFFFFFFFD, 1'b0, 32'hFFFFFFEB, 34);
    wait_result(60, 0);
    resync(); issue("mulh_11", MD_OP_MULH, 2'b11, 32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 34);
    wait_result(60, 0);
    resync(); issue("mulh_00", MD_OP_MULH, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 34);
    wait_result(60, 0);
    resync(); issue("mulh_01", MD_OP_MULH, 2'b01, 32'hFFFFFFFF, 32'd2, 1'b0, 32'hFFFFFFFF, 34);
    wait_result(60, 0);
    sel = 1;
    resync(); issue("mull_r4", MD_OP_MULL, 2'b11, 32'd7, 32'hFFFFFFFD, 1'b0, 32'hFFFFFFEB, 18);
    wait_result(60, 0);
    resync(); issue("mulh_r4", MD_OP_MULH, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 18);
    wait_result(60, 0);
    sel = 0;
  endtask

  task automatic test_div();
    resync(); issue("div_ovf", MD_OP_DIV, 2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 34);
    wait_result(60, 0);
    resync(); issue("rem_ovf", MD_OP_REM, 2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0, 34);
    wait_result(60, 0);
    resync(); issue("div_m7_2", MD_OP_DIV, 2'b11, 32'hFFFFFFF9, 32'd2, 1'b0, 32'hFFFFFFFD, 34);
    wait_result(60, 0);
    resync(); issue("rem_m7_2", MD_OP_REM, 2'b11, 32'hFFFFFFF9, 32'd2, 1'b0, 32'hFFFFFFFF, 34);
    wait_result(60, 0);
    resync(); issue("divu_mode01", MD_OP_DIV, 2'b01, 32'hFFFFFFF9, 32'd2, 1'b0, 32'h7FFFFFFC, 34);
    wait_result(60, 0);
  endtask

  task automatic test_div_zero();
    resync(); issue("div0_fast", MD_OP_DIV, 2'b00, 32'd100, 32'd0, 1'b0, 32'hFFFFFFFF, 2);
    wait_result(60, 0);
    resync(); issue("rem0_fast", MD_OP_REM, 2'b00, 32'd100, 32'd0, 1'b0, 32'd100, 2);
    wait_result(60, 0);
    resync(); issue("div0_fixed", MD_OP_DIV, 2'b00, 32'd100, 32'd0, 1'b1, 32'hFFFFFFFF, 34);
    wait_result(60, 0);
    resync(); issue("rem0_fixed", MD_OP_REM, 2'b00, 32'd100, 32'd0, 1'b1, 32'd100, 34);
    wait_result(60, 0);
    resync(); issue("div0_neg", MD_OP_DIV, 2'b11, 32'hFFFFFFFB, 32'd0, 1'b1, 32'hFFFFFFFF, 34);
    wait_result(60, 0);
    resync(); issue("rem0_neg", MD_OP_REM, 2'b11, 32'hFFFFFFFB, 32'd0, 1'b0, 32'hFFFFFFFB, 2);
    wait_result(60, 0);
  endtask

  task automatic test_kill();
    bit rose = 1'b0;
    exp_t dropped;
    resync();
    issue("div_killed", MD_OP_DIV, 2'b00, 32'd1000, 32'd3, 1'b0, 32'd333, 34);
    dropped = sb.pop_back();
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    checks++;
    if (ready_s !== 1'b1 || busy_s !== 1'b0 || valid_s !== 1'b0) begin
      errors++;
      $display("FAIL %s cycle11: ready=%b busy=%b valid=%b expected 1 0 0",
               dropped.name, ready_s, busy_s, valid_s);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid_s === 1'b1) rose = 1'b1;
    end
    checks++;
    if (rose) begin
      errors++;
      $display("FAIL kill_no_valid: valid_o rose after kill, expected never");
    end
    // kill together with start must not accept the request.
    operator = MD_OP_MULL; signed_mode = 2'b00; op_a = 32'd3; op_b = 32'd5;
    start = 1'b1; kill = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; kill = 1'b0;
    checks++;
    if (busy_s !== 1'b0) begin
      errors++;
      $display("FAIL kill_with_start: busy=%b expected 0", busy_s);
    end
    @(negedge clk);
    issue("mull_after_kill", MD_OP_MULL, 2'b00, 32'd3, 32'd5, 1'b0, 32'd15, 34);
    wait_result(60, 0);
  endtask

  task automatic test_reset_mid();
    exp_t dropped;
    resync();
    issue("mul_reset", MD_OP_MULL, 2'b00, 32'd9, 32'd9, 1'b0, 32'd81, 34);
    dropped = sb.pop_back();
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (valid_s !== 1'b0 || busy_s !== 1'b0 || ready_s !== 1'b1 || result_s !== 32'h0) begin
      errors++;
      $display("FAIL %s async: valid=%b busy=%b ready=%b result=%h expected 0 0 1 0",
               dropped.name, valid_s, busy_s, ready_s, result_s);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_backpressure();
    resync();
    rdy = 1'b0;
    issue("div_hold", MD_OP_DIV, 2'b11, 32'hFFFFFFF9, 32'd2, 1'b0, 32'hFFFFFFFD, 34);
    wait_result(60, 5);
    rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (valid_s !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: valid=%b expected 0", valid_s);
    end
  endtask

  task automatic test_back_to_back();
    resync();
    rdy = 1'b0;
    issue("b2b_first", MD_OP_MULL, 2'b11, 32'd7, 32'hFFFFFFFD, 1'b0, 32'hFFFFFFEB, 34);
    wait_result(60, 0);
    rdy = 1'b1;
    issue("b2b_second", MD_OP_REM, 2'b11, 32'hFFFFFFF9, 32'd2, 1'b0, 32'hFFFFFFFF, 34);
    wait_result(60, 0);
  endtask

  task automatic test_width8();
    sel = 2;
    resync(); issue("w8_divu", MD_OP_DIV, 2'b00, 32'd200, 32'd7, 1'b0, 32'd28, 10);
    wait_result(30, 0);
    resync(); issue("w8_remu", MD_OP_REM, 2'b00, 32'd200, 32'd7, 1'b0, 32'd4, 10);
    wait_result(30, 0);
    resync(); issue("w8_mulh", MD_OP_MULH, 2'b00, 32'd200, 32'd7, 1'b0, 32'd5, 10);
    wait_result(30, 0);
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_kill();
    test_reset_mid();
    test_backpressure();
    test_back_to_back();
    test_width8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ibex_multdiv_iter.md
Name: ibex_multdiv_iter

Overview:
Parametrised iterative multiply/divide unit for the EX stage. It supports any even operand width and a selectable multiplier radix. It has its own operand datapath, so it does not borrow the ALU adder. Compared with the current multdiv, it adds a full valid/ready result handshake, back-to-back issue, a kill input, and a selectable early-out for divide-by-zero. It sits beside the ALU; EX selects its result when an M-extension instruction is active.

Parameters:
Width, 32, operand/result width; even, >=4.
MulBitsPerCycle, 1, multiplier bits retired per CALC cycle; 1 or 2.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
start_i  in  1  request valid
ready_o  out  1  unit can accept a request this cycle
operator_i  in  ibex_pkg::md_op_e  MD_OP_MULL/MULH/DIV/REM
signed_mode_i  in  2  bit0: op_a signed; bit1: op_b signed
op_a_i  in  Width  operand A
op_b_i  in  Width  operand B
data_ind_timing_i  in  1  1 = fixed latency, no early-out
kill_i  in  1  abandon current operation
valid_o  out  1  result valid
ready_i  in  1  consumer accepts result
result_o  out  Width  result, stable while valid_o=1
busy_o  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, all registers 0. Output values: valid_o=0, result_o=0, busy_o=0, ready_o=1. Reset asserted mid-operation discards the operation immediately.
- Accept: accept = start_i & ready_o & ~kill_i.
- ready_o = (state==IDLE) | (state==DONE & ready_i).
- On accept, register operator, signs, operand magnitudes and the result-negate flag.
- States:
  - IDLE: accept -> CALC.
  - CALC: runs N cycles. N = Width/MulBitsPerCycle for MUL; N = Width for DIV/REM. Iteration counter decrements; after the last cycle -> FIX.
  - FIX: one cycle; applies two's-complement sign correction and selects the output half -> DONE.
  - DONE: valid_o=1. valid_o & ready_i -> IDLE, or -> CALC if a new accept occurs in the same cycle.
- Latency: accept at cycle 0 gives valid_o at cycle N+2.
- Early-out: DIV/REM with op_b==0 and data_ind_timing_i=0 skips CALC (IDLE -> FIX), so valid_o is at cycle 2. With data_ind_timing_i=1, full latency applies and the result is identical.
- Multiply:
  - Shift-add on magnitudes into a 2*Width accumulator. The product is negated if exactly one signed operand is negative.
  - MULL returns the low Width bits; signed_mode_i does not affect MULL.
  - MULH returns the high Width bits for modes 11 (signed x signed), 01 (signed x unsigned, a signed) and 00 (unsigned).
- Divide:
  - Restoring, one quotient bit per cycle, on magnitudes.
  - Quotient sign = sign(a) XOR sign(b); remainder takes the sign of a.
  - Signed only when signed_mode_i==11; all other values are unsigned.
  - Divide by zero: quotient = all ones; remainder = op_a_i.
  - Overflow (most negative / -1): quotient = most negative, remainder = 0. Produced by the normal datapath; no special case.
- Kill:
  - kill_i in any state forces IDLE next cycle and clears valid_o next cycle.
  - A killed operation never produces valid_o.
  - kill_i together with start_i does not accept the request.
- Stability: while valid_o=1 and ready_i=0, result_o and valid_o hold; input changes are ignored.
- result_o outside DONE is don't-care, except 0 after reset.

Decomposition:
- ibex_pkg:
  - add multdiv_iter_state_e {MD_IDLE, MD_CALC, MD_FIX, MD_DONE};
  - reuse md_op_e.
- Sub-module ibex_multdiv_iter_step: combinational per-cycle datapath covering the MUL add/shift for 1 or 2 bits, and the DIV trial subtract and restore. Parametrised by Width and MulBitsPerCycle.

Test Plan (Width=32 unless noted):
- MULL signed_mode=11, 7 x 0xFFFFFFFD, MulBitsPerCycle=1 -> result 0xFFFFFFEB, valid_o at cycle 34. Same with MulBitsPerCycle=2 -> valid_o at cycle 18.
- MULH mode 11, 0x80000000 x 0x80000000 -> 0x40000000. MULH mode 00, 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH mode 01, 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV mode 11, 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0. DIV mode 11, -7/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
- Divide by zero:
  - DIV mode 00, 100/0, data_ind_timing_i=0 -> 0xFFFFFFFF at cycle 2.
  - REM -> 100.
  - Repeat with data_ind_timing_i=1 -> same values at cycle 34.
- Kill and reset:
  - kill_i at cycle 10 of a DIV -> valid_o never rises; ready_o=1 at cycle 11; following MULL 3x5 -> 15.
  - rst_i pulse mid-MUL -> valid_o=0, busy_o=0 immediately.
- Backpressure and back-to-back:
  - Hold ready_i=0 for 5 cycles in DONE -> result_o and valid_o stable.
  - Assert ready_i together with start_i -> new op accepted that cycle; next valid_o at N+2.
  - Width=8 DIVU 200/7 -> 28, valid_o at cycle 10.
